// File: rtl/uinst_store_decode_if.sv
// Bundle between the microcode sequencer/loader and the microinstruction store.
// The store is the slave: it takes run/upc/ld_* and drives controls, loop counts and the micro-op.
interface uinst_store_decode_if #(
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int UINST_WIDTH      = 32
);
  logic                        run;
  logic [UINST_ADDR_WIDTH-1:0] upc;
  logic                        ld_en;
  logic [UINST_ADDR_WIDTH-1:0] ld_addr;
  logic [UINST_WIDTH-1:0]      ld_data;
  logic                        ld_err;
  logic [2:0]                  upc_up;
  logic [2:0]                  upc_st;
  logic                        done;
  logic [10:0]                 loop_0;
  logic [10:0]                 loop_1;
  logic [10:0]                 loop_2;
  logic                        op_valid;
  logic [5:0]                  op_code;
  logic [7:0]                  op_src;
  logic [7:0]                  op_dst;
  logic [15:0]                 uinst_cnt;
  logic                        dec_err;

  modport master (
    output run, upc, ld_en, ld_addr, ld_data,
    input  ld_err, upc_up, upc_st, done, loop_0, loop_1, loop_2,
           op_valid, op_code, op_src, op_dst, uinst_cnt, dec_err
  );

  modport slave (
    input  run, upc, ld_en, ld_addr, ld_data,
    output ld_err, upc_up, upc_st, done, loop_0, loop_1, loop_2,
           op_valid, op_code, op_src, op_dst, uinst_cnt, dec_err
  );
endinterface

// File: rtl/uinst_store_decode.sv
// Microinstruction store plus decoder: same-cycle loop/branch controls back to the sequencer,
// registered loop trip counts, and a one-stage datapath micro-op register.
module uinst_store_decode #(
  parameter int UINST_ADDR_WIDTH = 8,
  parameter int UINST_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  uinst_store_decode_if.slave  bus
);
  localparam int DEPTH = 1 << UINST_ADDR_WIDTH;

  // Store has no reset so the microprogram survives rst.
  logic [UINST_WIDTH-1:0] r_mem [DEPTH];

  logic [UINST_WIDTH-1:0] w_word;
  logic                   w_done;
  logic [2:0]             w_up;
  logic [2:0]             w_st;
  logic                   w_setloop;
  logic [1:0]             w_loop_sel;
  logic [10:0]            w_loop_imm;
  logic [10:0]            w_loop_val;
  logic [5:0]             w_op_code;
  logic [7:0]             w_op_src;
  logic [7:0]             w_op_dst;
  logic                   w_issue;
  logic                   w_illegal;
  logic                   w_run_rise;

  logic                   r_ld_err;
  logic [10:0]            r_loop_0;
  logic [10:0]            r_loop_1;
  logic [10:0]            r_loop_2;
  logic                   r_op_valid;
  logic [5:0]             r_op_code;
  logic [7:0]             r_op_src;
  logic [7:0]             r_op_dst;
  logic [15:0]            r_uinst_cnt;
  logic                   r_dec_err;
  logic                   r_run_d;

  assign w_word     = r_mem[bus.upc];
  assign w_done     = w_word[31];
  assign w_up       = w_word[30:28];
  assign w_st       = w_word[27:25];
  assign w_setloop  = w_word[24];
  assign w_loop_sel = w_word[23:22];
  assign w_loop_imm = w_word[21:11];
  assign w_op_code  = w_word[21:16];
  assign w_op_src   = w_word[15:8];
  assign w_op_dst   = w_word[7:0];

  // A zero trip count would never terminate the loop, so it runs once.
  assign w_loop_val = (w_loop_imm == 11'd0) ? 11'd1 : w_loop_imm;
  assign w_issue    = bus.run & ~w_setloop & ~w_done;
  assign w_run_rise = bus.run & ~r_run_d;
  assign w_illegal  = bus.run & ((w_setloop & (w_loop_sel == 2'd3)) |
                                 (w_st[2] & (w_st[1:0] == 2'd3)) |
                                 (w_up[2] & (w_up[1:0] == 2'd3)));

  always_ff @(posedge clk) begin
    if (bus.ld_en && !bus.run) begin
      r_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld_err    <= 1'b0;
      r_loop_0    <= 11'd1;
      r_loop_1    <= 11'd1;
      r_loop_2    <= 11'd1;
      r_op_valid  <= 1'b0;
      r_op_code   <= 6'd0;
      r_op_src    <= 8'd0;
      r_op_dst    <= 8'd0;
      r_uinst_cnt <= 16'd0;
      r_dec_err   <= 1'b0;
      r_run_d     <= 1'b0;
    end else begin
      r_ld_err <= bus.ld_en & bus.run;
      r_run_d  <= bus.run;

      if (bus.run && w_setloop) begin
        case (w_loop_sel)
          2'd0:    r_loop_0 <= w_loop_val;
          2'd1:    r_loop_1 <= w_loop_val;
          2'd2:    r_loop_2 <= w_loop_val;
          default: ;
        endcase
      end

      r_op_valid <= w_issue;
      if (w_issue) begin
        r_op_code <= w_op_code;
        r_op_src  <= w_op_src;
        r_op_dst  <= w_op_dst;
      end

      if (w_run_rise) begin
        r_uinst_cnt <= 16'd0;
      end else if (bus.run && (r_uinst_cnt != 16'hFFFF)) begin
        r_uinst_cnt <= r_uinst_cnt + 16'd1;
      end

      // An illegal word on the first cycle of a run still flags.
      r_dec_err <= (r_dec_err & ~w_run_rise) | w_illegal;
    end
  end

  assign bus.upc_up    = bus.run ? w_up   : 3'b000;
  assign bus.upc_st    = bus.run ? w_st   : 3'b000;
  assign bus.done      = bus.run ? w_done : 1'b0;
  assign bus.ld_err    = r_ld_err;
  assign bus.loop_0    = r_loop_0;
  assign bus.loop_1    = r_loop_1;
  assign bus.loop_2    = r_loop_2;
  assign bus.op_valid  = r_op_valid;
  assign bus.op_code   = r_op_code;
  assign bus.op_src    = r_op_src;
  assign bus.op_dst    = r_op_dst;
  assign bus.uinst_cnt = r_uinst_cnt;
  assign bus.dec_err   = r_dec_err;
endmodule
